// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The master side issues write/read requests; the slave side is the FIFO itself.
interface sync_fifo_flags_if #(
  parameter int DEP = 4,
  parameter int WID = 8
);
  localparam int CW = $clog2(DEP) + 1;

  logic           wr_i;
  logic           rd_i;
  logic [WID-1:0] wdata;
  logic [WID-1:0] rdata;
  logic           rvalid_o;
  logic           full_o;
  logic           empty_o;
  logic           almost_full_o;
  logic           almost_empty_o;
  logic [CW-1:0]  count_o;
  logic           overflow_o;
  logic           underflow_o;

  modport master (
    output wr_i, rd_i, wdata,
    input  rdata, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_i, rd_i, wdata,
    output rdata, rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o,
           count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered reads.
module sync_fifo_flags #(
  parameter int DEP    = 4,
  parameter int WID    = 8,
  parameter int AF_THR = DEP - 1,
  parameter int AE_THR = 1
) (
  input  logic               clk,
  input  logic               rst,
  sync_fifo_flags_if.slave   bus
);
  localparam int PW = $clog2(DEP);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEP);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THR);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THR);

  logic [WID-1:0] mem [DEP];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           wr_acc;
  logic           rd_acc;
  logic           ovf_p1;
  logic           unf_p1;

  function automatic logic [CW-1:0] next_count(input logic [CW-1:0] cur,
                                               input logic wr, input logic rd);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (wr && !rd)      nxt = cur + 1'b1;
    else if (!wr && rd) nxt = cur - 1'b1;
    return nxt;
  endfunction

  // Flags come only from the registered occupancy, never from the requests.
  assign full  = (count == FULL_LVL);
  assign empty = (count == '0);

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = bus.rd_i && !empty;
  assign wr_acc = bus.wr_i && (!full || rd_acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_p1 <= 1'b0;
      unf_p1 <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count  <= next_count(count, wr_acc, rd_acc);
      ovf_p1 <= bus.wr_i && !wr_acc;
      unf_p1 <= bus.rd_i && !rd_acc;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry is presented continuously; a read only acknowledges the pop.
  assign bus.rdata    = empty ? '0 : mem[rd_ptr];
  assign bus.rvalid_o = !empty;
`else
  logic [WID-1:0] rdata_p1;
  logic           rvalid_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1  <= '0;
      rvalid_p1 <= 1'b0;
    end else begin
      rvalid_p1 <= rd_acc;
      if (rd_acc) rdata_p1 <= mem[rd_ptr];
    end
  end

  assign bus.rdata    = rdata_p1;
  assign bus.rvalid_o = rvalid_p1;
`endif

  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.almost_full_o  = (count >= AF_LVL);
  assign bus.almost_empty_o = (count <= AE_LVL);
  assign bus.count_o        = count;
  assign bus.overflow_o     = ovf_p1;
  assign bus.underflow_o    = unf_p1;
endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter DEP, default 4, storage depth in entries; power of two, >=2.
REQ-002 SHALL have parameter WID, default 8, data width in bits, >=1.
REQ-003 SHALL have parameter AF_THR, default DEP-1, almost-full threshold, 1..DEP.
REQ-004 SHALL have parameter AE_THR, default 1, almost-empty threshold, 0..DEP-1.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous assert, active-high.
REQ-007 SHALL have port wr_i  input  1  write request.
REQ-008 SHALL have port rd_i  input  1  read request (FWFT build: pop acknowledge).
REQ-009 SHALL have port wdata  input  WID  write data.
REQ-010 SHALL have port rdata  output  WID  read data.
REQ-011 SHALL have port rvalid_o  output  1  rdata holds a valid popped word.
REQ-012 SHALL have port full_o  output  1  occupancy == DEP.
REQ-013 SHALL have port empty_o  output  1  occupancy == 0.
REQ-014 SHALL have port almost_full_o  output  1  occupancy >= AF_THR.
REQ-015 SHALL have port almost_empty_o  output  1  occupancy <= AE_THR.
REQ-016 SHALL have port count_o  output  $clog2(DEP)+1  current occupancy, 0..DEP.
REQ-017 SHALL have port overflow_o  output  1  one-cycle pulse on a rejected write.
REQ-018 SHALL have port underflow_o  output  1  one-cycle pulse on a rejected read.

Function
REQ-019 SHALL accept a write when wr_i=1 and (full_o=0 or a read is accepted in the same cycle).
REQ-020 SHALL accept a read when rd_i=1 and empty_o=0.
REQ-021 SHALL store wdata at the write pointer on an accepted write; pointers wrap from DEP-1 to 0.
REQ-022 SHALL update count_o +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-023 SHALL, when full and wr_i=rd_i=1, accept both; count stays DEP; no overflow.
REQ-024 SHALL, when empty and wr_i=rd_i=1, accept only the write, reject the read; count becomes 1; underflow_o pulses.
REQ-025 SHALL assert overflow_o for exactly the cycle after a rejected write; memory and pointers unchanged.
REQ-026 SHALL assert underflow_o for exactly the cycle after a rejected read; rdata unchanged.
REQ-027 SHALL derive full_o, empty_o, almost_full_o, almost_empty_o from registered count only; no combinational path from wr_i/rd_i.
REQ-028 SHALL preserve FIFO order: words read out equal words accepted, in acceptance order.

Reset
REQ-029 SHALL, on rst=1, immediately clear pointers and count: count_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0.
REQ-030 SHALL reset rdata=0, rvalid_o=0, overflow_o=0, underflow_o=0; memory contents are not cleared.
REQ-031 SHALL, on reset mid-operation, discard all stored words; the first post-reset read returns the first post-reset write.

Configuration
REQ-032 SHALL support macro SYNC_FIFO_FWFT_EN selecting first-word-fall-through mode.
REQ-033 SHALL, without SYNC_FIFO_FWFT_EN, register rdata from the head entry on an accepted read; rvalid_o=1 for one cycle after; rdata holds between reads (1-cycle read latency).
REQ-034 SHALL, with SYNC_FIFO_FWFT_EN, drive rdata with the head entry and rvalid_o=!empty_o continuously; an accepted rd_i pops the head and rdata shows the next entry the following cycle (0-cycle latency).

Verification (DEP=4, WID=8, AF_THR=3, AE_THR=1)
REQ-035 SHALL check: write 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full_o at count 3; full_o at 4; then read 4 -> rdata 0x11,0x22,0x33,0x44 in order, empty_o=1.
REQ-036 SHALL check: full FIFO, wr_i=1 with 0x55, rd_i=0 -> overflow_o one cycle, count 4, 0x55 never read.
REQ-037 SHALL check: empty FIFO, rd_i=1 alone -> underflow_o one cycle, rvalid_o=0, count 0.
REQ-038 SHALL check: full FIFO, wr_i=rd_i=1 with 0x66 -> 0x11 read, count stays 4, no overflow; 0x66 read last after 0x22..0x44.
REQ-039 SHALL check: 10 cycles wr_i=rd_i=1 from empty with 0xA0..0xA9 -> pointer wrap, underflow only in first cycle, reads 0xA0..0xA8 in order.
REQ-040 SHALL check: 2 words stored, rst pulsed mid-cycle -> count_o=0, empty_o=1 immediately; next write 0x77 then read returns 0x77.
